// File: rtl/addsub_pkg.sv
// Shared helpers for the chunked add/sub pipeline: stage count and signed
// saturation limits, all parametric in the operand width.
package addsub_pkg;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One carry-chain slice [HI:LO] of the pipelined adder; the last slice also
// derives signed overflow and applies saturation before registering.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LO    = 0,
  parameter int HI    = 3,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_bx,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  input  logic             in_sat,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_bx,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_sat,
  output logic             out_ovf
);

  localparam int CW = HI - LO + 1;
  localparam logic [WIDTH-1:0] CMASK = ((WIDTH'(1) << CW) - WIDTH'(1)) << LO;
  localparam logic [WIDTH-1:0] SMAX  = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN  = WIDTH'(sat_min(WIDTH));

  logic [CW:0]      part_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] a_d, a_q, bx_d, bx_q, sum_d, sum_q;
  logic             carry_d, carry_q, sat_d, sat_q, ovf_d, ovf_q;

  // Chunk add, merge into the partial sum, and (last slice) overflow/saturate.
  always_comb begin
    part_s = {1'b0, in_a[HI:LO]} + {1'b0, in_bx[HI:LO]} + {{CW{1'b0}}, in_carry};
    sum_s  = (in_sum & ~CMASK) | (WIDTH'(part_s[CW-1:0]) << LO);
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    ovf_s  = (in_a[WIDTH-1] ^ in_bx[WIDTH-1] ^ sum_s[WIDTH-1]) ^ part_s[CW];
    valid_d = valid_q;
    a_d     = a_q;
    bx_d    = bx_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    if (en) begin
      valid_d = in_valid;
      a_d     = in_a;
      bx_d    = in_bx;
      carry_d = part_s[CW];
      sat_d   = in_sat;
      ovf_d   = LAST ? ovf_s : 1'b0;
      if (LAST && in_sat && ovf_s) begin
        sum_d = in_a[WIDTH-1] ? SMIN : SMAX;
      end else begin
        sum_d = sum_s;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Slice state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      bx_q    <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_bx    = bx_q;
  assign out_sum   = sum_q;
  assign out_carry = carry_q;
  assign out_sat   = sat_q;
  assign out_ovf   = ovf_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined signed add/subtract with optional saturation, valid/ready flow
// control and a saturating overflow event counter.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             carry_out,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int STAGES = ceil_div(WIDTH, CHUNK);

  logic             adv_s;
  logic             v_w     [0:STAGES];
  logic [WIDTH-1:0] a_w     [0:STAGES];
  logic [WIDTH-1:0] bx_w    [0:STAGES];
  logic [WIDTH-1:0] sum_w   [0:STAGES];
  logic             c_w     [0:STAGES];
  logic             sat_w   [0:STAGES];
  logic             ovf_w   [0:STAGES];
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // The whole pipe stalls together; a slot moves only if the output is free.
  always_comb begin
    adv_s = !out_valid || out_ready;
  end

  assign in_ready = adv_s;
  assign v_w[0]   = in_valid;
  assign a_w[0]   = a;
  assign bx_w[0]  = b ^ {WIDTH{sub}};
  assign sum_w[0] = {WIDTH{1'b0}};
  assign c_w[0]   = sub;
  assign sat_w[0] = sat;
  assign ovf_w[0] = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int HI = (LO + CHUNK > WIDTH) ? WIDTH - 1 : LO + CHUNK - 1;
    addsub_stage #(
      .WIDTH (WIDTH),
      .LO    (LO),
      .HI    (HI),
      .LAST  (k == STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv_s),
      .in_valid  (v_w[k]),
      .in_a      (a_w[k]),
      .in_bx     (bx_w[k]),
      .in_sum    (sum_w[k]),
      .in_carry  (c_w[k]),
      .in_sat    (sat_w[k]),
      .out_valid (v_w[k+1]),
      .out_a     (a_w[k+1]),
      .out_bx    (bx_w[k+1]),
      .out_sum   (sum_w[k+1]),
      .out_carry (c_w[k+1]),
      .out_sat   (sat_w[k+1]),
      .out_ovf   (ovf_w[k+1])
    );
  end

  assign out_valid = v_w[STAGES];
  assign s         = sum_w[STAGES];
  assign overflow  = ovf_w[STAGES];
  assign carry_out = c_w[STAGES];
  assign ovf_count = cnt_q;

  // Overflow event counter: clear wins over a coincident count, sticks at max.
  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (out_valid && out_ready && overflow && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 SHALL have parameter CHUNK, default 4, carry-chain bits per pipeline stage (1..WIDTH); STAGES = ceil(WIDTH/CHUNK).
REQ-003 SHALL have parameter CNT_W, default 16, overflow-counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  operand beat offered.
REQ-008 in_ready  out  1  operand beat accepted when in_valid && in_ready.
REQ-009 a, b  in  WIDTH each  signed two's-complement operands.
REQ-010 sub  in  1  0 = a+b, 1 = a-b; sampled with the beat.
REQ-011 sat  in  1  1 = saturate on overflow, 0 = wrap; sampled with the beat.
REQ-012 out_valid  out  1  result beat present.
REQ-013 out_ready  in  1  result consumed when out_valid && out_ready.
REQ-014 s  out  WIDTH  signed result.
REQ-015 overflow  out  1  signed overflow of this beat (before saturation).
REQ-016 carry_out  out  1  raw carry from MSB (sub: 1 = no borrow).
REQ-017 ovf_clr  in  1  synchronous clear of ovf_count.
REQ-018 ovf_count  out  CNT_W  count of accepted-at-output beats with overflow=1.

Function
REQ-019 Subtraction SHALL be computed as a + ~b + 1 (carry-in = sub).
REQ-020 Stage k SHALL add chunk k using the registered carry from stage k-1; upper-chunk operands and sub/sat flags SHALL be delayed to align; last chunk may be narrower than CHUNK.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid with no stall.
REQ-022 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-023 Pipeline SHALL advance only when !out_valid || out_ready; in_ready SHALL equal that condition (no bubbles collapsed, no beat lost or duplicated).
REQ-024 s, overflow, carry_out SHALL hold stable while out_valid && !out_ready.
REQ-025 overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-026 With sat=1 and overflow=1, s SHALL be 2^(WIDTH-1)-1 when the true result is positive (sign of a = 0) else -2^(WIDTH-1); otherwise s SHALL be the wrapped sum.
REQ-027 ovf_count SHALL increment once per output handshake with overflow=1 and saturate at all-ones.
REQ-028 ovf_clr coincident with a counted handshake SHALL yield ovf_count = 0 (clear wins).
REQ-029 Bubbles (in_valid=0) SHALL propagate as invalid slots with no effect on ovf_count.

Reset
REQ-030 rst_n=0 SHALL immediately clear all stage valid bits, out_valid=0, s=0, overflow=0, carry_out=0, ovf_count=0; in-flight beats are discarded.
REQ-031 in_ready SHALL be 1 during and after reset.
REQ-032 First beat after rst_n release SHALL be accepted on the first clk edge with in_valid=1.

Structure
REQ-033 Shared package addsub_pkg SHALL hold the stage-count function ceil_div and the saturation-limit constants as width-parametric functions.
REQ-034 One sub-module addsub_stage (one CHUNK slice: operand register, partial sum, carry register, valid bit) SHALL be instantiated STAGES times.

Verification (WIDTH=8, CHUNK=4 unless stated)
REQ-035 a=100, b=27, sub=0, sat=0 -> after 2 cycles s=127, overflow=0, carry_out=0.
REQ-036 a=100, b=28, sub=0: sat=0 -> s=-128, overflow=1; sat=1 -> s=127, overflow=1; ovf_count=2.
REQ-037 a=-128, b=1, sub=1: sat=0 -> s=127, overflow=1, carry_out=1; sat=1 -> s=-128.
REQ-038 20 back-to-back beats, out_ready low for cycles 5-8 -> in_ready=0 those cycles, all 20 results in order, s stable while stalled.
REQ-039 rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, ovf_count=0, no stale result after release.
REQ-040 WIDTH=4, CHUNK=2 and WIDTH=5, CHUNK=2: exhaustive all a, b, sub, sat -> s/overflow/carry_out match reference model, 0 errors.
